// File: rtl/atten_mix_scheduler.sv
// ---------------------------------------------------------------------------
// atten_mix_scheduler
//
// Shares one combinational attenuation lookup (4-bit code -> amplitude,
// 2 dB/step, all-ones = silence) among all PSG channels. On a sample strobe
// it snapshots the channel output bits and commits the staged attenuation
// codes. It then walks the channels one per cycle through the lookup,
// accumulates the amplitudes and publishes one mixed sample.
//
// Optional build macro: ATTEN_RAMP_EN
//   defined   : at each commit every active code steps one code toward its
//               staged code, so volume changes are click-free.
//   undefined : active codes take the staged codes directly at commit.
//
// Handshake: start is a single-cycle strobe with no ready. It is accepted
//   only when the FSM is IDLE at the sampling edge. A start seen in any
//   other state is dropped, and overrun pulses for one cycle. mix_valid is
//   a one-cycle pulse that marks the cycle in which mix_out takes a new
//   value. mix_out holds that value until the next frame completes.
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-high reset
//   start       sample strobe, begins one mix frame
//   chan_in     current 1-bit output of each channel
//   wr_en       attenuation register write strobe
//   wr_chan     target channel of the write (out-of-range is ignored)
//   wr_atten    attenuation code to write
//   lut_in      to the shared lookup's in
//   lut_control to the shared lookup's control
//   lut_out     from the shared lookup (combinational)
//   mix_out     last completed mixed sample
//   mix_valid   one-cycle pulse when mix_out updates
//   busy        high while a frame is in progress
//   overrun     one-cycle pulse when start is ignored
// ---------------------------------------------------------------------------
module atten_mix_scheduler #(
  parameter int CHANNELS     = 4,
  parameter int CONTROL_BITS = 4,
  parameter int VOLUME_BITS  = 15,
  localparam int IDX_BITS    = $clog2(CHANNELS),
  localparam int SUM_BITS    = VOLUME_BITS + $clog2(CHANNELS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [CHANNELS-1:0]     chan_in,
  input  logic                    wr_en,
  input  logic [IDX_BITS-1:0]     wr_chan,
  input  logic [CONTROL_BITS-1:0] wr_atten,
  output logic                    lut_in,
  output logic [CONTROL_BITS-1:0] lut_control,
  input  logic [VOLUME_BITS-1:0]  lut_out,
  output logic [SUM_BITS-1:0]     mix_out,
  output logic                    mix_valid,
  output logic                    busy,
  output logic                    overrun
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_q;
  logic [CONTROL_BITS-1:0] staged_q [CHANNELS];
  logic [CONTROL_BITS-1:0] active_q [CHANNELS];
  logic [CHANNELS-1:0]     snap_q;
  logic [IDX_BITS-1:0]     idx_q;
  logic [SUM_BITS-1:0]     acc_q;
  logic [SUM_BITS-1:0]     mix_q;
  logic                    valid_q;
  logic                    overrun_q;

  logic [SUM_BITS-1:0]     acc_d;
  logic [IDX_BITS-1:0]     idx_d;
  logic                    wr_ok;
  logic                    scan_last;

  // Out-of-range channel numbers only exist when CHANNELS is not a power of two.
  assign wr_ok     = wr_en && (int'(wr_chan) < CHANNELS);
  assign acc_d     = acc_q + {{(SUM_BITS-VOLUME_BITS){1'b0}}, lut_out};
  assign idx_d     = idx_q + IDX_BITS'(1);
  assign scan_last = (idx_q == IDX_BITS'(CHANNELS-1));

  // The lookup is driven straight from registers so the lookup result is
  // usable in the same cycle. Outside SCAN it is parked at silence.
  assign lut_in      = (state_q == ST_SCAN) ? snap_q[idx_q]   : 1'b0;
  assign lut_control = (state_q == ST_SCAN) ? active_q[idx_q] : '1;

  assign mix_out   = mix_q;
  assign mix_valid = valid_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      snap_q    <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      mix_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        staged_q[i] <= '1;
        active_q[i] <= '1;
      end
    end else begin
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;

      // The commit below reads staged_q before this write lands, so a write
      // coinciding with a commit only affects the following frame.
      if (wr_ok) begin
        staged_q[wr_chan] <= wr_atten;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            snap_q  <= chan_in;
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= ST_SCAN;
            for (int i = 0; i < CHANNELS; i++) begin
`ifdef ATTEN_RAMP_EN
              if (active_q[i] < staged_q[i]) begin
                active_q[i] <= active_q[i] + CONTROL_BITS'(1);
              end else if (active_q[i] > staged_q[i]) begin
                active_q[i] <= active_q[i] - CONTROL_BITS'(1);
              end
`else
              active_q[i] <= staged_q[i];
`endif
            end
          end
        end
        ST_SCAN: begin
          acc_q <= acc_d;
          idx_q <= idx_d;
          if (scan_last) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          mix_q   <= acc_q;
          valid_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      if (start && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_atten_mix_scheduler.sv
// ---------------------------------------------------------------------------
// Bench for atten_mix_scheduler. Provides the shared attenuation lookup
// (32767 * 10^(-code/10), rounded down, code 15 = silence). Keeps a
// frame-level reference model: each accepted start produces a known sum that
// is due CHANNELS+1 edges later.
// ---------------------------------------------------------------------------
module tb_atten_mix_scheduler;

  localparam int CH  = 4;
  localparam int CB  = 4;
  localparam int VB  = 15;
  localparam int IB  = 2;
  localparam int SB  = 17;

  // clock / reset
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          start;
  logic [CH-1:0] chan_in;
  logic          wr_en;
  logic [IB-1:0] wr_chan;
  logic [CB-1:0] wr_atten;
  logic          lut_in;
  logic [CB-1:0] lut_control;
  logic [VB-1:0] lut_out;
  logic [SB-1:0] mix_out;
  logic          mix_valid;
  logic          busy;
  logic          overrun;

  atten_mix_scheduler #(
    .CHANNELS(CH), .CONTROL_BITS(CB), .VOLUME_BITS(VB)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .chan_in(chan_in),
    .wr_en(wr_en), .wr_chan(wr_chan), .wr_atten(wr_atten),
    .lut_in(lut_in), .lut_control(lut_control), .lut_out(lut_out),
    .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy), .overrun(overrun)
  );

  // shared attenuation lookup
  int tbl [16];
  initial begin
    for (int k = 0; k < 15; k++) begin
      tbl[k] = $rtoi($floor(32767.0 * $pow(10.0, -k / 10.0)));
    end
    tbl[15] = 0;
  end
  assign lut_out = lut_in ? VB'(tbl[lut_control]) : '0;

  // scoreboard counters
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: frame-level timing and sums
  int staged_m [CH];
  int active_m [CH];
  int snap_m   [CH];
  int cyc_n       = 0;
  int frame_start = -1;
  int frame_sum   = 0;
  int mix_out_m   = 0;
  bit mix_valid_m = 0;
  bit overrun_m   = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        staged_m[i] = 15;
        active_m[i] = 15;
        snap_m[i]   = 0;
      end
      cyc_n       = 0;
      frame_start = -1;
      frame_sum   = 0;
      mix_out_m   = 0;
      mix_valid_m = 0;
      overrun_m   = 0;
    end else begin
      bit acc_ok;
      cyc_n++;
      mix_valid_m = (frame_start >= 0) && (cyc_n == frame_start + CH + 1);
      if (mix_valid_m) mix_out_m = frame_sum;
      acc_ok    = start && ((frame_start < 0) || (cyc_n >= frame_start + CH + 2));
      overrun_m = start && !acc_ok;
      if (acc_ok) begin
        frame_start = cyc_n;
        frame_sum   = 0;
        for (int i = 0; i < CH; i++) begin
          snap_m[i] = int'(chan_in[i]);
`ifdef ATTEN_RAMP_EN
          if (active_m[i] < staged_m[i]) active_m[i] = active_m[i] + 1;
          else if (active_m[i] > staged_m[i]) active_m[i] = active_m[i] - 1;
`else
          active_m[i] = staged_m[i];
`endif
          if (snap_m[i] != 0) frame_sum += tbl[active_m[i]];
        end
      end
      if (wr_en) staged_m[int'(wr_chan)] = int'(wr_atten);
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    int k;
    int exp_in;
    int exp_ctl;
    bit busy_m;
    busy_m  = (frame_start >= 0) && (cyc_n - frame_start <= CH);
    k       = cyc_n - frame_start;
    exp_in  = 0;
    exp_ctl = 15;
    if (busy_m && k < CH) begin
      exp_in  = snap_m[k];
      exp_ctl = active_m[k];
    end
    check("busy",        int'(busy),        int'(busy_m));
    check("mix_valid",   int'(mix_valid),   int'(mix_valid_m));
    check("mix_out",     int'(mix_out),     mix_out_m);
    check("overrun",     int'(overrun),     int'(overrun_m));
    check("lut_in",      int'(lut_in),      exp_in);
    check("lut_control", int'(lut_control), exp_ctl);
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic write_att(input int ch, input int v);
    wr_en    = 1'b1;
    wr_chan  = IB'(ch);
    wr_atten = CB'(v);
    cyc();
    wr_en    = 1'b0;
  endtask

  task automatic do_frame(input logic [CH-1:0] ch, output int res, output int lat);
    chan_in = ch;
    start   = 1'b1;
    cyc();
    start   = 1'b0;
    res     = -1;
    lat     = -1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (mix_valid) begin
        res = int'(mix_out);
        lat = k;
        break;
      end
    end
    if (lat < 0) check("frame_timeout", 0, 1);
  endtask

  // stimulus
  int res;
  int lat;
  int n_ovr;
  int n_val;
  int last_mix;

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    chan_in  = '0;
    wr_en    = 1'b0;
    wr_chan  = '0;
    wr_atten = '0;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();

    // reset state
    check("rst_mix_out",     int'(mix_out),     0);
    check("rst_lut_control", int'(lut_control), 15);
    check("rst_busy",        int'(busy),        0);

    // all channels silent
    do_frame(4'b1111, res, lat);
    check("latency", lat, 5);
    check("silent_mix", res, 0);

    write_att(0, 0);
    do_frame(4'b0001, res, lat);
`ifndef ATTEN_RAMP_EN
    check("ch0_full", res, 32767);
`endif
    do_frame(4'b0000, res, lat);
    check("ch_off", res, 0);

    for (int i = 0; i < CH; i++) write_att(i, 0);
    do_frame(4'b1111, res, lat);
`ifndef ATTEN_RAMP_EN
    check("all_full", res, 131068);
`endif
    write_att(2, 3);
    write_att(3, 15);
    do_frame(4'b1111, res, lat);
`ifndef ATTEN_RAMP_EN
    check("mixed_codes", res, 81956);
`endif

    // start every cycle for 12 cycles; write to ch0 on the second commit
    n_ovr    = 0;
    n_val    = 0;
    last_mix = -1;
    chan_in  = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      start    = 1'b1;
      wr_en    = (c == 6);
      wr_chan  = '0;
      wr_atten = 4'd5;
      cyc();
      if (overrun) n_ovr++;
      if (mix_valid) begin
        n_val++;
        last_mix = int'(mix_out);
      end
    end
    start = 1'b0;
    wr_en = 1'b0;
    for (int c = 0; c < 8; c++) begin
      cyc();
      if (mix_valid) begin
        n_val++;
        last_mix = int'(mix_out);
      end
    end
    check("burst_overruns", n_ovr, 10);
    check("burst_frames", n_val, 2);
`ifndef ATTEN_RAMP_EN
    check("burst_write_deferred", last_mix, 32767);
`endif
    do_frame(4'b0001, res, lat);
`ifndef ATTEN_RAMP_EN
    check("burst_write_applied", res, 10361);
`endif

    // reset in the middle of SCAN (idx = 2)
    chan_in = 4'b1111;
    start   = 1'b1;
    cyc();
    start   = 1'b0;
    cyc();
    cyc();
    #1 reset = 1'b1;
    #1;
    check("mid_rst_busy",        int'(busy),        0);
    check("mid_rst_mix_valid",   int'(mix_valid),   0);
    check("mid_rst_mix_out",     int'(mix_out),     0);
    check("mid_rst_lut_in",      int'(lut_in),      0);
    check("mid_rst_lut_control", int'(lut_control), 15);
    check("mid_rst_overrun",     int'(overrun),     0);
    cyc();
    cyc();
    reset = 1'b0;
    n_val = 0;
    for (int c = 0; c < 8; c++) begin
      cyc();
      if (mix_valid) n_val++;
    end
    check("aborted_no_valid", n_val, 0);
    write_att(0, 0);
    write_att(1, 1);
    write_att(2, 2);
    write_att(3, 3);
    do_frame(4'b1011, res, lat);
    check("post_rst_latency", lat, 5);

`ifdef ATTEN_RAMP_EN
    // ramp: fresh reset, ch0 staged 0, active walks down one code per frame
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    write_att(0, 0);
    for (int f = 1; f <= 16; f++) begin
      do_frame(4'b0001, res, lat);
      check("ramp_frame", res, tbl[(f >= 15) ? 0 : 15 - f]);
      if (f == 1)  check("ramp_frame1", res, 1304);
      if (f == 15) check("ramp_frame15", res, 32767);
      if (f == 16) check("ramp_frame16", res, 32767);
    end
`endif

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      start    = ($urandom_range(0, 3) == 0);
      chan_in  = CH'($urandom_range(0, 15));
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_chan  = IB'($urandom_range(0, CH - 1));
      wr_atten = CB'($urandom_range(0, 15));
      cyc();
    end
    start = 1'b0;
    wr_en = 1'b0;
    repeat (10) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
